dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-master arbiter sharing the single data-RAM port of the SoC (the `dram_driver` port: combinational read, write committed at the clock edge) between the CPU core data port (master 0) and a secondary requester such as a loader/DMA (master 1). Per cycle it selects one requester, muxes its address/data/mask/write-enable onto the RAM port and returns read data one cycle later on a registered response. Fairness between the masters comes from round-robin, bounded bus locking and an out-of-window address check.

## Interface
- `MAX_HOLD`, default 8: maximum consecutive locked grants a master may hold while the other master is requesting (range 1..255).
- `WIN_BASE`, default 32'h0000_0000: base of the RAM window; only `addr[31:18]` is compared against `WIN_BASE[31:18]`.
- `clk`  in  1  system clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `mX_req`, X=0,1  in  1  access request; held until `mX_gnt`.
- `mX_lock`  in  1  request to keep ownership on the following cycle.
- `mX_wen`  in  1  1 = write, 0 = read.
- `mX_addr`  in  32  byte address.
- `mX_wdata`  in  32  write data.
- `mX_mask`  in  3  access size/sign code, passed through unchanged.
- `mX_gnt`  out  1  combinational; access is performed this cycle.
- `mX_rvalid`  out  1  registered; response for the access granted in the previous cycle.
- `mX_rdata`  out  32  registered read data; 0 for writes and errors.
- `mX_err`  out  1  registered; previous granted access was outside the window.
- `s_addr`  out  18  RAM address = granted `addr[17:0]`, 0 when idle.
- `s_wdata`  out  32  granted write data, 0 when idle.
- `s_mask`  out  3  granted mask, 0 when idle.
- `s_wen`  out  1  granted write enable, gated by the window check.
- `s_rdata`  in  32  combinational RAM read data.

## Operation
- State: `owner` (IDLE / M0 / M1), `last` (last granted master, reset 1 so that M0 wins the first tie), `hold_cnt` (8-bit, saturating at `MAX_HOLD`).
- Grant decision, priority order:
  - (a) `owner`=Mk, `mk_req`=1, `mk_lock`=1, and either `hold_cnt` < `MAX_HOLD` or the other master is idle: grant Mk.
  - (b) Both masters request: grant the master that is not `last`.
  - (c) One master requests: grant it.
  - (d) Neither requests: no grant; `s_*` outputs are driven to 0.
- At most one `mX_gnt` is high per cycle. A master that is not granted must hold its request fields stable.
- Window check: in-window when `addr[31:18]` == `WIN_BASE[31:18]`. Out-of-window: `s_wen` is forced to 0, the response has `err`=1 and `rdata`=0.
- Update on each edge with a grant to Mk:
  - `last`←k.
  - `owner`←Mk if `mk_lock`, else IDLE.
  - `hold_cnt`←`hold_cnt`+1 if Mk was already `owner`, else 1. It saturates at `MAX_HOLD`.
- Update on an edge with no grant: `owner`←IDLE, `hold_cnt`←0.
- Response register, on the edge after a grant to Mk:
  - `mk_rvalid`←1.
  - `mk_rdata`←`s_rdata` for an in-window read, else 0.
  - `mk_err`←window fail.
  - The other master's `rvalid`/`err` are cleared; `rdata` holds its last value.
- Back-to-back grants to the same master give one `rvalid` per grant, in order.

## Timing
- Grant: 0-cycle (combinational from `req`/`lock`/state). Write commit: the edge ending the grant cycle. Read response: `rvalid` is high in cycle N+1 for a grant in cycle N.
- Reset (`rst_n`=0, asynchronous): `owner`=IDLE, `last`=1, `hold_cnt`=0, all `rvalid`/`err`/`rdata`=0.
- During reset, `mX_gnt`=0 and `s_wen`=0 regardless of the inputs.
- Reset released mid-transaction: the pending response is discarded and there is no `rvalid`. The master must re-request.
- Simultaneous release of lock by the owner and a request by the other master: rule (b) applies in that same cycle.
- Lock held while the other master is idle: ownership is unbounded and `hold_cnt` stays saturated. The forced switch occurs in the first cycle the other master requests with `hold_cnt`=`MAX_HOLD`.
- A lock request with `req`=0 is ignored; `owner` goes to IDLE.

## Test plan
- **Reset:** assert `rst_n`=0 with both `req`=1 → `gnt`=00, `s_wen`=0, all `rvalid`=0. Release → first cycle grants m0 (tie, `last`=1).
- **Round-robin:** both masters request continuously without lock → grants alternate m0, m1, m0, m1. Each `rvalid` appears exactly one cycle after the master's grant.
- **Write/read:** m1 writes 32'hA5A5_1234 to 0x0000_0040, then m0 reads 0x0000_0040 → m0 `rdata`=32'hA5A5_1234 with `rvalid`=1 in the cycle after the read grant, `err`=0.
- **Lock bound:** `MAX_HOLD`=4; m0 holds `req`+`lock`; m1 requests from cycle 2 → m0 gets 4 consecutive grants, then m1 is granted. m0 gets no further grant until m1 is served.
- **Window error:** m0 writes to 0x0004_0000 with `WIN_BASE`=0 → `s_wen`=0, RAM content unchanged, next cycle `m0_err`=1, `m0_rdata`=0.
- **Mid-operation reset:** m1 is granted a read, `rst_n` is pulsed low before the next edge → no `m1_rvalid`, `owner`=IDLE, arbitration restarts from the reset state.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-master arbiter for the single data-RAM port: round-robin with bounded
// locking, address-window check and a registered per-master response.
module dmem_arbiter #(
    parameter int unsigned MAX_HOLD = 8,
    parameter logic [31:0] WIN_BASE = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m0_req,
    input  logic        m0_lock,
    input  logic        m0_wen,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [2:0]  m0_mask,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,
    output logic        m0_err,
    input  logic        m1_req,
    input  logic        m1_lock,
    input  logic        m1_wen,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [2:0]  m1_mask,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,
    output logic        m1_err,
    output logic [17:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [2:0]  s_mask,
    output logic        s_wen,
    input  logic [31:0] s_rdata
);

    typedef enum logic [1:0] {
        OWN_IDLE,
        OWN_M0,
        OWN_M1
    } owner_t;

    localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);

    owner_t      owner_q, owner_d, sel_own;
    logic        last_q, last_d;
    logic [7:0]  hold_q, hold_d;
    logic        keep0, keep1;
    logic        g0, g1, any_gnt;
    logic [31:0] sel_addr, sel_wdata, rd_val;
    logic [2:0]  sel_mask;
    logic        sel_wen, sel_lock, in_win;

    // Lock is honoured until the bound, but only while the other side waits
    assign keep0 = (owner_q == OWN_M0) && m0_req && m0_lock
                   && ((hold_q < HOLD_MAX) || !m1_req);
    assign keep1 = (owner_q == OWN_M1) && m1_req && m1_lock
                   && ((hold_q < HOLD_MAX) || !m0_req);

    always_comb begin
        g0 = 1'b0;
        g1 = 1'b0;
        if (!rst_n) begin
            g0 = 1'b0;
        end else if (keep0) begin
            g0 = 1'b1;
        end else if (keep1) begin
            g1 = 1'b1;
        end else if (m0_req && m1_req) begin
            g0 = last_q;
            g1 = !last_q;
        end else if (m0_req) begin
            g0 = 1'b1;
        end else if (m1_req) begin
            g1 = 1'b1;
        end
    end

    assign m0_gnt  = g0;
    assign m1_gnt  = g1;
    assign any_gnt = g0 | g1;

    assign sel_addr  = g1 ? m1_addr  : m0_addr;
    assign sel_wdata = g1 ? m1_wdata : m0_wdata;
    assign sel_mask  = g1 ? m1_mask  : m0_mask;
    assign sel_wen   = g1 ? m1_wen   : m0_wen;
    assign sel_lock  = g1 ? m1_lock  : m0_lock;
    assign sel_own   = g1 ? OWN_M1   : OWN_M0;
    assign in_win    = (sel_addr[31:18] == WIN_BASE[31:18]);

    assign s_addr  = any_gnt ? sel_addr[17:0] : 18'd0;
    assign s_wdata = any_gnt ? sel_wdata : 32'd0;
    assign s_mask  = any_gnt ? sel_mask : 3'd0;
    assign s_wen   = any_gnt & sel_wen & in_win;
    assign rd_val  = (in_win && !sel_wen) ? s_rdata : 32'd0;

    always_comb begin
        owner_d = OWN_IDLE;
        last_d  = last_q;
        hold_d  = 8'd0;
        if (any_gnt) begin
            last_d  = g1;
            owner_d = sel_lock ? sel_own : OWN_IDLE;
            if (owner_q != sel_own) begin
                hold_d = 8'd1;
            end else if (hold_q >= HOLD_MAX) begin
                hold_d = HOLD_MAX;
            end else begin
                hold_d = hold_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q <= OWN_IDLE;
            last_q  <= 1'b1;
            hold_q  <= 8'd0;
        end else begin
            owner_q <= owner_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m0_rvalid <= 1'b0;
            m0_err    <= 1'b0;
            m0_rdata  <= 32'd0;
            m1_rvalid <= 1'b0;
            m1_err    <= 1'b0;
            m1_rdata  <= 32'd0;
        end else begin
            m0_rvalid <= g0;
            m0_err    <= g0 & !in_win;
            m1_rvalid <= g1;
            m1_err    <= g1 & !in_win;
            if (g0) begin
                m0_rdata <= rd_val;
            end
            if (g1) begin
                m1_rdata <= rd_val;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small behavioural data RAM
// behind the shared port.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_req, m0_lock, m0_wen;
    logic [31:0] m0_addr, m0_wdata;
    logic [2:0]  m0_mask;
    logic        m0_gnt, m0_rvalid, m0_err;
    logic [31:0] m0_rdata;
    logic        m1_req, m1_lock, m1_wen;
    logic [31:0] m1_addr, m1_wdata;
    logic [2:0]  m1_mask;
    logic        m1_gnt, m1_rvalid, m1_err;
    logic [31:0] m1_rdata;
    logic [17:0] s_addr;
    logic [31:0] s_wdata;
    logic [2:0]  s_mask;
    logic        s_wen;
    logic [31:0] s_rdata;

    logic [31:0] mem [0:255];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    assign s_rdata = mem[s_addr[9:2]];

    always @(posedge clk) begin
        if (s_wen) mem[s_addr[9:2]] <= s_wdata;
    end

    dmem_arbiter #(
        .MAX_HOLD(4),
        .WIN_BASE(32'h0000_0000)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_lock(m0_lock), .m0_wen(m0_wen),
        .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_mask(m0_mask),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m0_err(m0_err),
        .m1_req(m1_req), .m1_lock(m1_lock), .m1_wen(m1_wen),
        .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_mask(m1_mask),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .m1_err(m1_err),
        .s_addr(s_addr), .s_wdata(s_wdata), .s_mask(s_mask),
        .s_wen(s_wen), .s_rdata(s_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    function automatic logic [31:0] gnt2();
        return {30'd0, m1_gnt, m0_gnt};
    endfunction

    function automatic logic [31:0] rv2();
        return {30'd0, m1_rvalid, m0_rvalid};
    endfunction

    initial begin
        rst_n   = 1'b0;
        m0_req  = 1'b1; m0_lock = 1'b0; m0_wen = 1'b1;
        m0_addr = 32'h100; m0_wdata = 32'h0; m0_mask = 3'd2;
        m1_req  = 1'b1; m1_lock = 1'b0; m1_wen = 1'b1;
        m1_addr = 32'h104; m1_wdata = 32'h0; m1_mask = 3'd2;

        // reset with both requesting writes
        cyc();
        chk("rst_gnt", gnt2(), 32'd0);
        chk("rst_swen", {31'd0, s_wen}, 32'd0);
        chk("rst_rvalid", rv2(), 32'd0);
        chk("rst_rdata0", m0_rdata, 32'd0);

        // release: round-robin reads, m0 first
        m0_wen = 1'b0;
        m1_wen = 1'b0;
        rst_n  = 1'b1;
        settle();
        chk("rr_g1", gnt2(), 32'd1);
        cyc();
        chk("rr_rv1", rv2(), 32'd1);
        chk("rr_g2", gnt2(), 32'd2);
        cyc();
        chk("rr_rv2", rv2(), 32'd2);
        chk("rr_g3", gnt2(), 32'd1);
        cyc();
        chk("rr_rv3", rv2(), 32'd1);
        chk("rr_g4", gnt2(), 32'd2);
        cyc();
        chk("rr_rv4", rv2(), 32'd2);
        m0_req = 1'b0;
        m1_req = 1'b0;
        settle();
        chk("idle_gnt", gnt2(), 32'd0);
        chk("idle_saddr", {14'd0, s_addr}, 32'd0);
        cyc();
        chk("idle_rv", rv2(), 32'd0);

        // m1 writes, m0 reads back
        m1_req = 1'b1; m1_wen = 1'b1;
        m1_addr = 32'h40; m1_wdata = 32'hA5A5_1234; m1_mask = 3'd2;
        settle();
        chk("wr_gnt", gnt2(), 32'd2);
        chk("wr_swen", {31'd0, s_wen}, 32'd1);
        chk("wr_saddr", {14'd0, s_addr}, 32'h40);
        chk("wr_smask", {29'd0, s_mask}, 32'd2);
        cyc();
        chk("wr_rv", rv2(), 32'd2);
        chk("wr_rdata", m1_rdata, 32'd0);
        chk("wr_err", {31'd0, m1_err}, 32'd0);
        m1_req = 1'b0; m1_wen = 1'b0;
        m0_req = 1'b1; m0_wen = 1'b0; m0_addr = 32'h40;
        settle();
        chk("rd_gnt", gnt2(), 32'd1);
        cyc();
        chk("rd_rv", rv2(), 32'd1);
        chk("rd_rdata", m0_rdata, 32'hA5A5_1234);
        chk("rd_err", {31'd0, m0_err}, 32'd0);
        m0_req = 1'b0;
        cyc();

        // lock bound of 4 with m1 waiting from the second cycle
        m0_req = 1'b1; m0_lock = 1'b1;
        settle();
        chk("lk_g1", gnt2(), 32'd1);
        cyc();
        m1_req = 1'b1; m1_addr = 32'h44;
        for (int i = 2; i <= 4; i++) begin
            settle();
            chk($sformatf("lk_g%0d", i), gnt2(), 32'd1);
            cyc();
        end
        settle();
        chk("lk_g5", gnt2(), 32'd2);
        cyc();
        chk("lk_rv5", rv2(), 32'd2);
        m1_req = 1'b0;
        settle();
        chk("lk_g6", gnt2(), 32'd1);
        cyc();
        m0_req = 1'b0; m0_lock = 1'b0;
        cyc();

        // in-window write to 0, then an out-of-window write aliasing it
        m0_req = 1'b1; m0_wen = 1'b1;
        m0_addr = 32'h0; m0_wdata = 32'h1111_2222;
        cyc();
        m0_addr = 32'h0004_0000; m0_wdata = 32'hDEAD_BEEF;
        settle();
        chk("win_gnt", gnt2(), 32'd1);
        chk("win_swen", {31'd0, s_wen}, 32'd0);
        cyc();
        chk("win_err", {31'd0, m0_err}, 32'd1);
        chk("win_rdata", m0_rdata, 32'd0);
        chk("win_rv", rv2(), 32'd1);
        m0_wen = 1'b0; m0_addr = 32'h0;
        cyc();
        chk("win_keep", m0_rdata, 32'h1111_2222);
        chk("win_err2", {31'd0, m0_err}, 32'd0);
        m0_addr = 32'h0004_0000;
        cyc();
        chk("win_rderr", {31'd0, m0_err}, 32'd1);
        chk("win_rdzero", m0_rdata, 32'd0);
        m0_req = 1'b0;
        cyc();

        // mid-operation reset kills the pending m1 write
        m1_req = 1'b1; m1_wen = 1'b1;
        m1_addr = 32'h40; m1_wdata = 32'h0000_0BAD;
        settle();
        chk("mr_gnt", gnt2(), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_gnt_rst", gnt2(), 32'd0);
        chk("mr_swen_rst", {31'd0, s_wen}, 32'd0);
        cyc();
        chk("mr_rv", rv2(), 32'd0);
        rst_n = 1'b1;
        m1_wen = 1'b0; m1_addr = 32'h44;
        m0_req = 1'b1; m0_wen = 1'b0; m0_addr = 32'h40;
        settle();
        chk("mr_tie", gnt2(), 32'd1);
        cyc();
        chk("mr_rv2", rv2(), 32'd1);
        chk("mr_ram", m0_rdata, 32'hA5A5_1234);
        m0_req = 1'b0;
        m1_req = 1'b0;
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
